// File: rtl/seg_scan_driver_pkg.sv
// Shared types and helpers for the multiplexed segment scan driver.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package seg_scan_driver_pkg;

  // Per-slot phase of the scan FSM.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2,
    ST_OFF   = 2'd3
  } scan_state_t;

  // Bits needed to hold values 0..v-1; never less than one bit so that
  // single-value ranges still produce a legal vector.
  function automatic int clog2w(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_scan_driver_timer.sv
// Slot counter (cnt) and digit index (idx) with slot/frame wrap strobes.
// Latency: strobes are combinational from the registered counters.
// Backpressure: none; advances every clock while run_i is high.
// Ports: clk/rst, clr_i (synchronous clear), run_i (advance), cnt_o, idx_o,
//        slot_end_o (last clock of a slot), frame_end_o (last clock of a frame).
module scan_timer #(
  parameter int unsigned NUM_SEG  = 6,
  parameter int unsigned SCAN_DIV = 50000,
  parameter int          CW       = 16,
  parameter int          IW       = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          run_i,
  output logic [CW-1:0] cnt_o,
  output logic [IW-1:0] idx_o,
  output logic          slot_end_o,
  output logic          frame_end_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;

  assign slot_end_o  = run_i && (cnt_q == CW'(SCAN_DIV - 1));
  assign frame_end_o = slot_end_o && (idx_q == IW'(NUM_SEG - 1));

  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (clr_i) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (run_i) begin
      if (slot_end_o) begin
        cnt_d = '0;
        idx_d = frame_end_o ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign cnt_o = cnt_q;
  assign idx_o = idx_q;

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment(+dp) scan driver with blanking and PWM brightness.
// Latency: outputs registered, aligned with the FSM state of the same cycle.
// Backpressure: none; en=0 aborts the frame and parks in IDLE next edge.
// Ports: clk, rst (async active-high), en, bright[3:0], seg_in[8*NUM_SEG-1:0]
//        -> seg_out[7:0], dig_sel[NUM_SEG-1:0] (one-hot), frame_done (pulse).
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int unsigned NUM_SEG   = 6,
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 1000,
  parameter bit          ACT_LOW   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [3:0]           bright,
  input  logic [8*NUM_SEG-1:0] seg_in,
  output logic [7:0]           seg_out,
  output logic [NUM_SEG-1:0]   dig_sel,
  output logic                 frame_done
);

  localparam int CW = clog2w(int'(SCAN_DIV));
  localparam int IW = clog2w(int'(NUM_SEG));
  // on_len can reach SCAN_DIV-BLANK_CYC, so size it for SCAN_DIV inclusive.
  localparam int OW = clog2w(int'(SCAN_DIV) + 1);
  localparam int unsigned ON_UNIT = (SCAN_DIV - BLANK_CYC) >> 4;

  if (SCAN_DIV < BLANK_CYC + 16 || NUM_SEG < 1) begin : g_bad_params
    $error("seg_scan_driver: illegal parameters (need SCAN_DIV>=BLANK_CYC+16, NUM_SEG>=1)");
  end

  scan_state_t          state_q, state_d;
  logic [8*NUM_SEG-1:0] frame_buf_q;
  logic [3:0]           bright_s_q;
  logic [7:0]           seg_out_q;
  logic [NUM_SEG-1:0]   dig_sel_q;
  logic                 frame_done_q;

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          slot_end, frame_end;
  logic          tmr_clr, tmr_run;
  logic          load;
  logic [3:0]    bright_eff;
  logic [OW-1:0] on_len;
  logic [31:0]   cnt_nx, on_end;
  logic [7:0]    seg_d;
  logic [NUM_SEG-1:0] dig_d;

  assign tmr_run = en && (state_q != ST_IDLE);
  assign tmr_clr = !tmr_run;

  scan_timer #(
    .NUM_SEG (NUM_SEG),
    .SCAN_DIV(SCAN_DIV),
    .CW      (CW),
    .IW      (IW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (tmr_clr),
    .run_i      (tmr_run),
    .cnt_o      (cnt),
    .idx_o      (idx),
    .slot_end_o (slot_end),
    .frame_end_o(frame_end)
  );

  // Brightness is captured during cnt=0; in that cycle the live input is
  // used so the slot's on_len is consistent from its first clock.
  assign bright_eff = (cnt == '0) ? bright : bright_s_q;
  assign on_len     = OW'(ON_UNIT * (32'(bright_eff) + 32'd1));
  assign cnt_nx     = 32'(cnt) + 32'd1;
  assign on_end     = BLANK_CYC + 32'(on_len);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_IDLE) begin
      state_d = ST_BLANK;
      load    = 1'b1;
    end else if (slot_end) begin
      state_d = ST_BLANK;
      load    = frame_end;
    end else if (cnt_nx < BLANK_CYC) begin
      state_d = ST_BLANK;
    end else if (cnt_nx < on_end) begin
      state_d = ST_ON;
    end else begin
      state_d = ST_OFF;
    end
  end

  // idx and frame_buf only change on edges that lead into BLANK, so their
  // current values are the ones valid whenever the next state is ON.
  always_comb begin
    seg_d = '0;
    dig_d = '0;
    if (state_d == ST_ON) begin
      seg_d = frame_buf_q[{idx, 3'b000} +: 8];
      dig_d = NUM_SEG'(1) << idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      frame_buf_q  <= '0;
      bright_s_q   <= '0;
      frame_done_q <= 1'b0;
      seg_out_q    <= {8{ACT_LOW}};
      dig_sel_q    <= {NUM_SEG{ACT_LOW}};
    end else begin
      state_q      <= state_d;
      if (load) frame_buf_q <= seg_in;
      if (tmr_run && cnt == '0) bright_s_q <= bright;
      frame_done_q <= frame_end;
      seg_out_q    <= seg_d ^ {8{ACT_LOW}};
      dig_sel_q    <= dig_d ^ {NUM_SEG{ACT_LOW}};
    end
  end

  assign seg_out    = seg_out_q;
  assign dig_sel    = dig_sel_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (NUM_SEG=4, SCAN_DIV=40, BLANK_CYC=4).
// Latency: samples outputs on the falling edge; k counts clocks from slot0 cnt=0.
// Backpressure: n/a.
module tb_seg_scan_driver;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  bright;
  logic [31:0] seg_in;
  logic [7:0]  seg_out;
  logic [3:0]  dig_sel;
  logic        frame_done;

  int n_chk;
  int n_bad;

  seg_scan_driver #(
    .NUM_SEG  (4),
    .SCAN_DIV (40),
    .BLANK_CYC(4),
    .ACT_LOW  (1'b0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .bright    (bright),
    .seg_in    (seg_in),
    .seg_out   (seg_out),
    .dig_sel   (dig_sel),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Checks n consecutive cycles starting at frame position k0. ON spans
  // cnt 4..4+onl-1; frame_done is due at the first clock of each new frame.
  task automatic win(input string tag, input int k0, input int n, input int onl,
                     input logic [31:0] frm);
    for (int i = 0; i < n; i++) begin
      int k, s, c;
      bit on;
      logic [7:0] es;
      logic [3:0] ed;
      k  = k0 + i;
      s  = (k / 40) % 4;
      c  = k % 40;
      on = (c >= 4) && (c < 4 + onl);
      es = on ? frm[8*s +: 8] : 8'h00;
      ed = on ? (4'b0001 << s) : 4'b0000;
      chk({tag, "_seg"}, 32'(seg_out), 32'(es));
      chk({tag, "_dig"}, 32'(dig_sel), 32'(ed));
      chk({tag, "_fd"}, 32'(frame_done), ((k > 0) && (k % 160 == 0)) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
  endtask

  // en low for one edge, high on the next: leaves us at slot0 cnt=0.
  task automatic restart();
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    n_chk  = 0;
    n_bad  = 0;
    rst    = 1'b0;
    en     = 1'b0;
    bright = 4'd15;
    seg_in = 32'h0;
    #1 rst = 1'b1;
    #1;
    chk("rst_seg", 32'(seg_out), 32'h0);
    chk("rst_dig", 32'(dig_sel), 32'h0);
    chk("rst_fd", 32'(frame_done), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Full brightness: 4 blank, 32 on, 4 off per slot; frame every 160.
    seg_in = 32'hA1B2C3D4;
    restart();
    win("full", 0, 200, 32, 32'hA1B2C3D4);

    // Minimum brightness: 2 on clocks at cnt 4..5.
    bright = 4'd0;
    restart();
    win("dim", 0, 160, 2, 32'hA1B2C3D4);

    // Mid-frame seg_in change: no tearing, new bytes next frame.
    bright = 4'd15;
    restart();
    win("tear0", 0, 50, 32, 32'hA1B2C3D4);
    seg_in = 32'h55667788;
    win("tear1", 50, 110, 32, 32'hA1B2C3D4);
    win("tear2", 160, 45, 32, 32'h55667788);

    // Abort during slot2 ON, then re-enable with a fresh snapshot.
    seg_in = 32'hA1B2C3D4;
    restart();
    win("abt0", 0, 90, 32, 32'hA1B2C3D4);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abt_seg", 32'(seg_out), 32'h0);
      chk("abt_dig", 32'(dig_sel), 32'h0);
      chk("abt_fd", 32'(frame_done), 32'h0);
    end
    seg_in = 32'h0F1E2D3C;
    en = 1'b1;
    @(negedge clk);
    win("abt1", 0, 50, 32, 32'h0F1E2D3C);

    // Asynchronous reset in the middle of ON.
    seg_in = 32'hA1B2C3D4;
    restart();
    win("ar0", 0, 10, 32, 32'hA1B2C3D4);
    chk("ar_pre_dig", 32'(dig_sel), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("ar_seg", 32'(seg_out), 32'h0);
    chk("ar_dig", 32'(dig_sel), 32'h0);
    chk("ar_fd", 32'(frame_done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    win("ar1", 0, 50, 32, 32'hA1B2C3D4);

    // Brightness change mid-slot takes effect at the next slot.
    restart();
    win("br0", 0, 10, 32, 32'hA1B2C3D4);
    bright = 4'd3;
    win("br1", 10, 30, 32, 32'hA1B2C3D4);
    win("br2", 40, 40, 8, 32'hA1B2C3D4);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
